// File: rtl/fadd_issue.sv
// Issue/sequencing wrapper around an external combinational single-precision adder.
// A 2-entry request FIFO feeds an IDLE/EXEC/DONE engine that waits LAT cycles per result.
module fadd_issue #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_x1,
    input  logic [31:0] in_x2,
    input  logic [4:0]  in_tag,
    output logic [31:0] fa_x1,
    output logic [31:0] fa_x2,
    input  logic [31:0] fa_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic [4:0]  out_tag,
    input  logic        flush,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [4:0]  tag;
    } req_t;

    req_t        fifo [2];
    req_t        head;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    state_t      state;
    logic [2:0]  lat_cnt;
    logic [4:0]  cur_tag;
    logic        push;
    logic        load;
    logic [31:0] prep_x1;
    logic [31:0] prep_x2;

    assign head     = fifo[rd_ptr];
    assign in_ready = (count < 2'd2);
    assign busy     = (count != 2'd0) || (state != IDLE);
    assign push     = in_valid && in_ready && !flush;
    // A new operation is loaded from IDLE, or straight out of DONE when the result is taken.
    assign load     = !flush && (count != 2'd0) &&
                      ((state == IDLE) || ((state == DONE) && out_ready));

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        prep_x1 = head.x1;
        prep_x2 = head.x2;
        case (head.op)
            2'b01: prep_x2 = {~head.x2[31], head.x2[30:0]};
            2'b10: begin
                prep_x1 = head.x2;
                prep_x2 = {~head.x1[31], head.x1[30:0]};
            end
            default: ;
        endcase
    end

    // NOTE: FIFO storage has no reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= '{op: in_op, x1: in_x1, x2: in_x2, tag: in_tag};
        end
    end

    // NOTE: sequential state uses non-blocking assignments; a later assignment in the block wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= 32'd0;
            out_tag   <= 5'd0;
            fa_x1     <= 32'd0;
            fa_x2     <= 32'd0;
            lat_cnt   <= 3'd0;
            cur_tag   <= 5'd0;
        end else if (flush) begin
            state     <= IDLE;
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (load) rd_ptr <= ~rd_ptr;
            case ({push, load})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase

            case (state)
                EXEC: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        out_y     <= fa_y;
                        out_tag   <= cur_tag;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase

            if (load) begin
                fa_x1   <= prep_x1;
                fa_x2   <= prep_x2;
                cur_tag <= head.tag;
                lat_cnt <= 3'(LAT);
                state   <= EXEC;
            end
        end
    end

endmodule

// File: tb/tb_fadd_issue.sv
// Self-checking bench for fadd_issue: a real-valued adder on fa_x*/fa_y, a queue-based
// reference model, directed scenarios with literal expectations, then randomized traffic.
module tb_fadd_issue;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush;
    logic [1:0]  in_op;
    logic [31:0] in_x1, in_x2;
    logic [4:0]  in_tag;
    logic        in_ready, out_valid, busy;
    logic [31:0] fa_x1, fa_x2, fa_y, out_y;
    logic [4:0]  out_tag;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [4:0]  tag;
        int          acc;
    } mop_t;

    mop_t q[$];
    int   head_issue = 0;
    int   e = 0;
    bit   rst_chk = 0;
    logic [4:0] log_tag[$];
    int   log_edge[$];

    fadd_issue #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag), .fa_x1(fa_x1), .fa_x2(fa_x2),
        .fa_y(fa_y), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_tag(out_tag), .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic real f2r(logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        int ex;
        d  = $realtobits(r);
        ex = int'(d[62:52]) - 1023 + 127;
        if (d[62:52] == 11'd0 || ex <= 0) return {d[63], 31'd0};
        if (ex >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(ex), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(logic [31:0] a, logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    assign fa_y = fp_add(fa_x1, fa_x2);

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
        end
    endtask

    function automatic bit m_issued();
        return (q.size() > 0) && (head_issue <= e);
    endfunction

    function automatic bit m_valid();
        return (q.size() > 0) && (head_issue + LAT <= e);
    endfunction

    function automatic bit m_ready();
        return (q.size() - (m_issued() ? 1 : 0)) < 2;
    endfunction

    task automatic compare();
        if (rst_chk) begin
            check("rst_out_y", out_y, 0);
            check("rst_out_tag", out_tag, 0);
            check("rst_fa_x1", fa_x1, 0);
            check("rst_fa_x2", fa_x2, 0);
        end
        check("in_ready", in_ready, m_ready());
        check("busy", busy, q.size() > 0);
        check("out_valid", out_valid, m_valid());
        if (m_valid()) begin
            check("out_y", out_y, q[0].y);
            check("out_tag", out_tag, q[0].tag);
        end
        if (m_issued()) begin
            check("fa_x1", fa_x1, q[0].a);
            check("fa_x2", fa_x2, q[0].b);
        end
    endtask

    // Advance one clock: update the model for the coming edge, then sample on the falling edge.
    task automatic tick();
        bit   rdy, vld;
        mop_t m;
        rdy = m_ready();
        vld = m_valid();
        if (out_valid === 1'b1 && out_ready && !rst && !flush) begin
            log_tag.push_back(out_tag);
            log_edge.push_back(e + 1);
        end
        if (rst) begin
            q.delete();
            rst_chk = 1;
        end else begin
            rst_chk = 0;
            if (flush) begin
                q.delete();
            end else begin
                if (vld && out_ready) begin
                    void'(q.pop_front());
                    if (q.size() > 0)
                        head_issue = (q[0].acc + 1 > e + 1) ? q[0].acc + 1 : e + 1;
                end
                if (in_valid && rdy) begin
                    case (in_op)
                        2'b01:   begin m.a = in_x1; m.b = in_x2 ^ 32'h8000_0000; end
                        2'b10:   begin m.a = in_x2; m.b = in_x1 ^ 32'h8000_0000; end
                        default: begin m.a = in_x1; m.b = in_x2; end
                    endcase
                    m.y   = fp_add(m.a, m.b);
                    m.tag = in_tag;
                    m.acc = e + 1;
                    if (q.size() == 0) head_issue = e + 2;
                    q.push_back(m);
                end
            end
        end
        e++;
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic drive(logic [1:0] op, logic [31:0] x1, logic [31:0] x2, logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_x1    = x1;
        in_x2    = x2;
        in_tag   = tag;
    endtask

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
    endfunction

    initial begin
        bit rdy_seen [4];
        bit got;

        rst = 1; in_valid = 0; out_ready = 0; flush = 0;
        in_op = 0; in_x1 = 0; in_x2 = 0; in_tag = 0;
        @(negedge clk);
        tick();
        tick();
        rst = 0;
        tick();
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);

        // Pin the reference adder itself.
        check("model_add", fp_add(32'h3F80_0000, 32'h4000_0000), 32'h4040_0000);
        check("model_neg", fp_add(32'h3F80_0000, 32'hC040_0000), 32'hC000_0000);

        // add, LAT=1: valid two edges after acceptance, one cycle wide.
        out_ready = 1;
        drive(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd5);
        tick();
        in_valid = 0;
        check("add_valid_n", out_valid, 0);
        tick();
        check("add_valid_n1", out_valid, 0);
        tick();
        check("add_valid_n2", out_valid, 1);
        check("add_y", out_y, 32'h4040_0000);
        check("add_tag", out_tag, 5'd5);
        tick();
        check("add_one_wide", out_valid, 0);

        // sub and rsub.
        drive(2'b01, 32'h4040_0000, 32'h3F80_0000, 5'd6);
        tick();
        in_valid = 0;
        tick();
        check("sub_fa_x1", fa_x1, 32'h4040_0000);
        check("sub_fa_x2", fa_x2, 32'hBF80_0000);
        tick();
        check("sub_y", out_y, 32'h4000_0000);
        tick();
        drive(2'b10, 32'h4040_0000, 32'h3F80_0000, 5'd7);
        tick();
        in_valid = 0;
        tick();
        check("rsub_fa_x1", fa_x1, 32'h3F80_0000);
        check("rsub_fa_x2", fa_x2, 32'hC040_0000);
        tick();
        check("rsub_y", out_y, 32'hC000_0000);
        tick();

        // Capacity: 3 accepted with out_ready low, then drained in order without IDLE gaps.
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drive(2'($urandom), rnd_fp(), rnd_fp(), 5'(10 + i));
            rdy_seen[i] = in_ready;
            tick();
        end
        in_valid = 0;
        check("cap_rdy0", rdy_seen[0], 1);
        check("cap_rdy1", rdy_seen[1], 1);
        check("cap_rdy2", rdy_seen[2], 1);
        check("cap_rdy3", rdy_seen[3], 0);
        repeat (3) tick();
        log_tag.delete();
        log_edge.delete();
        out_ready = 1;
        repeat (8) tick();
        check("cap_count", log_tag.size(), 3);
        if (log_tag.size() == 3) begin
            check("cap_tag0", log_tag[0], 5'd10);
            check("cap_tag1", log_tag[1], 5'd11);
            check("cap_tag2", log_tag[2], 5'd12);
            check("cap_gap01", log_edge[1] - log_edge[0], LAT + 1);
            check("cap_gap12", log_edge[2] - log_edge[1], LAT + 1);
        end

        // Flush during EXEC, with a push in the flush cycle that must be dropped.
        drive(2'b00, rnd_fp(), rnd_fp(), 5'd20);
        tick();
        drive(2'b00, rnd_fp(), rnd_fp(), 5'd21);
        tick();
        flush = 1;
        drive(2'b01, rnd_fp(), rnd_fp(), 5'd22);
        tick();
        flush = 0;
        in_valid = 0;
        check("flx_valid", out_valid, 0);
        check("flx_busy", busy, 0);
        check("flx_ready", in_ready, 1);

        // Flush while DONE with two requests queued.
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive(2'($urandom), rnd_fp(), rnd_fp(), 5'(23 + i));
            tick();
        end
        in_valid = 0;
        tick();
        flush = 1;
        tick();
        flush = 0;
        check("fld_valid", out_valid, 0);
        check("fld_busy", busy, 0);
        check("fld_ready", in_ready, 1);
        out_ready = 1;
        drive(2'b00, 32'h4000_0000, 32'h4000_0000, 5'd30);
        tick();
        in_valid = 0;
        tick();
        tick();
        check("post_flush_valid", out_valid, 1);
        check("post_flush_y", out_y, 32'h4080_0000);
        check("post_flush_tag", out_tag, 5'd30);
        tick();

        // Reset while a result is waiting in DONE.
        out_ready = 0;
        drive(2'b00, 32'h3F80_0000, 32'h3F80_0000, 5'd9);
        tick();
        in_valid = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = (out_valid === 1'b1);
        end
        check("rst_wait_valid", got, 1);
        rst = 1;
        tick();
        rst = 0;
        check("rst_valid", out_valid, 0);
        check("rst_y", out_y, 0);
        check("rst_tag", out_tag, 0);
        check("rst_x1", fa_x1, 0);
        check("rst_x2", fa_x2, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        log_tag.delete();
        out_ready = 1;
        repeat (5) tick();
        check("rst_no_delivery", log_tag.size(), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_op     = 2'($urandom);
            in_x1     = rnd_fp();
            in_x2     = rnd_fp();
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 199) < 1);
            tick();
        end
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        repeat (10) tick();
        check("drain_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
